// File: rtl/and_arbiter_pkg.sv
// ============================================================================
// Module : and_arbiter_pkg
// Brief  : Shared defaults, ID width and output-register state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package and_arbiter_pkg;

    localparam int c_DEF_NREQ  = 4;
    localparam int c_DEF_WIDTH = 16;
    localparam int c_DEF_ID_W  = (c_DEF_NREQ > 1) ? $clog2(c_DEF_NREQ) : 1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage : and_arbiter_pkg

`default_nettype wire

// File: rtl/AndX16.sv
// ============================================================================
// Module : AndX16
// Brief  : 16-bit bitwise AND, purely combinational.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module AndX16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);

    assign o_y = i_a & i_b;

endmodule : AndX16

`default_nettype wire

// File: rtl/and_arbiter.sv
// ============================================================================
// Module : and_arbiter
// Brief  : Round-robin arbiter sharing one AND unit between NREQ requesters,
//          with a single registered result stage (EMPTY/FULL).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_arbiter
    import and_arbiter_pkg::*;
#(
    parameter int NREQ  = c_DEF_NREQ,
    parameter int WIDTH = c_DEF_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NREQ-1:0]                       req_valid,
    output logic [NREQ-1:0]                       req_ready,
    input  logic [NREQ*WIDTH-1:0]                 req_a,
    input  logic [NREQ*WIDTH-1:0]                 req_b,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [WIDTH-1:0]                      rsp_data,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id
);

    localparam int          c_ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned c_NREQ_U = NREQ;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [WIDTH-1:0]    r_rsp_data;
    logic [c_ID_W-1:0]   r_rsp_id;

    logic                w_can_accept;
    logic                w_gnt_found;
    logic [c_ID_W-1:0]   w_gnt_idx;
    logic                w_xfer;
    logic [NREQ-1:0]     w_req_ready;
    logic [WIDTH-1:0]    w_op_a;
    logic [WIDTH-1:0]    w_op_b;
    logic [WIDTH-1:0]    w_and;

    // (base + off) mod NREQ; off never exceeds NREQ so one subtraction suffices.
    function automatic logic [c_ID_W-1:0] f_wrap_add(input logic [c_ID_W-1:0] base,
                                                     input int unsigned       off);
        int unsigned s;
        s = {{(32-c_ID_W){1'b0}}, base} + off;
        if (s >= c_NREQ_U) begin
            s = s - c_NREQ_U;
        end
        return s[c_ID_W-1:0];
    endfunction

    assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;

    always_comb begin : p_arb
        logic [c_ID_W-1:0] v_idx;
        v_idx       = '0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int unsigned k = 0; k < c_NREQ_U; k++) begin
            v_idx = f_wrap_add(r_rr_ptr, k);
            if (!w_gnt_found && req_valid[v_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = v_idx;
            end
        end
    end

    // Gating with rst_n keeps req_ready low for the whole reset window.
    assign w_xfer = w_gnt_found && w_can_accept && rst_n;

    always_comb begin : p_ready
        w_req_ready = '0;
        if (w_xfer) begin
            w_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin : p_opmux
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == c_ID_W'(i)) begin
                w_op_a = req_a[i*WIDTH +: WIDTH];
                w_op_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    AndX16 u_and (
        .i_a (w_op_a),
        .i_b (w_op_b),
        .o_y (w_and)
    );

    always_comb begin : p_fsm_nxt
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && rsp_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_fsm_reg
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_data_reg
        if (!rst_n) begin
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
            r_rr_ptr   <= '0;
        end else if (w_xfer) begin
            r_rsp_data <= w_and;
            r_rsp_id   <= w_gnt_idx;
            r_rr_ptr   <= f_wrap_add(w_gnt_idx, 1);
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

endmodule : and_arbiter

`default_nettype wire
